bram_arbiter: RTL

- Sequences and shares the single-port user BRAM between two requesters:
  - the Wishbone slave port (firmware access at the user-project base address);
  - a FIR engine memory port (tap and data buffer traffic).
- Wishbone accesses keep the programmable wait-state latency; engine accesses are single-cycle issue with no wait states.
- Round-robin arbitration with registered read-data return to each requester.

---
 rtl/bram_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one single-port BRAM between the Wishbone slave and the FIR engine
module bram_arbiter #(
  parameter logic [31:0] ADDR_BASE = 32'h3800_0000,
  parameter int          DELAYS    = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        eng_req_i,
  input  logic [3:0]  eng_we_i,
  input  logic [31:0] eng_addr_i,
  input  logic [31:0] eng_dat_i,
  output logic        eng_gnt_o,
  output logic        eng_rvalid_o,
  output logic [31:0] eng_rdata_o,
  output logic [3:0]  bram_WE,
  output logic        bram_EN,
  output logic [31:0] bram_A,
  output logic [31:0] bram_Di,
  input  logic [31:0] bram_Do
);
  typedef enum logic [2:0] {WB_IDLE, WB_WAIT, WB_PEND, WB_RDAT, WB_ACK} wb_state_t;
  wb_state_t   r_state, w_next;
  logic [31:0] r_cnt, w_cnt_next;
  logic        r_last_eng;
  logic        r_eng_rd;
  logic        w_wb_req, w_wb_gnt, w_eng_gnt;
  logic [31:0] w_wb_addr;
  assign w_wb_addr = (wbs_adr_i - ADDR_BASE) >> 2;
  assign w_wb_req  = (r_state == WB_PEND) && wbs_cyc_i;
  // On a conflict the requester that did not win last time goes first
  assign w_wb_gnt  = w_wb_req && (!eng_req_i || r_last_eng);
  // Gated by reset so no grant is advertised while the block is held in reset
  assign w_eng_gnt = wb_rst_i && eng_req_i && !w_wb_gnt;
  assign eng_gnt_o = w_eng_gnt;
  assign wbs_ack_o = (r_state == WB_ACK);
  assign bram_EN   = w_wb_gnt || w_eng_gnt;
  assign bram_WE   = w_wb_gnt ? (wbs_we_i ? wbs_sel_i : 4'h0) : (w_eng_gnt ? eng_we_i : 4'h0);
  assign bram_A    = w_wb_gnt ? w_wb_addr : (w_eng_gnt ? eng_addr_i : 32'h0);
  assign bram_Di   = w_wb_gnt ? wbs_dat_i : (w_eng_gnt ? eng_dat_i : 32'h0);
  // Wishbone sequencing: wait states, BRAM request, read capture, ack pulse
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      WB_IDLE: begin
        w_cnt_next = 32'h0;
        if (wbs_stb_i && wbs_cyc_i) w_next = (DELAYS == 1) ? WB_PEND : WB_WAIT;
      end
      WB_WAIT: begin
        w_cnt_next = r_cnt + 32'h1;
        w_next     = !wbs_cyc_i ? WB_IDLE : (r_cnt == 32'(DELAYS - 2)) ? WB_PEND : WB_WAIT;
      end
      WB_PEND: w_next = !wbs_cyc_i ? WB_IDLE : !w_wb_gnt ? WB_PEND : wbs_we_i ? WB_ACK : WB_RDAT;
      WB_RDAT: w_next = WB_ACK;
      default: w_next = WB_IDLE;
    endcase
  end
  // Wishbone state and wait counter
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state <= WB_IDLE;
      r_cnt   <= 32'h0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end
  // Remember who issued last, starting as if the engine had, so Wishbone wins the first conflict
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) r_last_eng <= 1'b1;
    else if (bram_EN) r_last_eng <= w_eng_gnt;
  end
  // Wishbone read data is taken from the BRAM the cycle after its issue and held
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) wbs_dat_o <= 32'h0;
    else if (r_state == WB_RDAT) wbs_dat_o <= bram_Do;
  end
  // Engine read return pipeline: issue, BRAM output cycle, registered data with valid pulse
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_eng_rd     <= 1'b0;
      eng_rvalid_o <= 1'b0;
      eng_rdata_o  <= 32'h0;
    end else begin
      r_eng_rd     <= w_eng_gnt && (eng_we_i == 4'h0);
      eng_rvalid_o <= r_eng_rd;
      if (r_eng_rd) eng_rdata_o <= bram_Do;
    end
  end
endmodule
